// File: rtl/kab_uart_tx_if.sv
// KabIO register-bus bundle for the UART transmitter: write/read strobes, word address and data.
// The master drives the strobes and the slave returns registered read data.
interface kab_uart_tx_if;
   logic        Sys_WrEn;
   logic        Sys_RdEn;
   logic [1:0]  Sys_Address;
   logic [31:0] Sys_WrData;
   logic [31:0] Sys_RdData;

   modport master (
      output Sys_WrEn, Sys_RdEn, Sys_Address, Sys_WrData,
      input  Sys_RdData
   );

   modport slave (
      input  Sys_WrEn, Sys_RdEn, Sys_Address, Sys_WrData,
      output Sys_RdData
   );
endinterface

// File: rtl/kab_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: small TX FIFO, programmable bit period (BAUD+1 cycles),
// registered serial line and a level interrupt raised when the transmitter drains.
module kab_uart_tx #(
   parameter int          FIFO_DEPTH = 4,
   parameter int          DIV_W      = 16,
   parameter int unsigned DIV_RESET  = 433
) (
   input  logic            Sys_Clock,
   input  logic            Sys_Reset,
   kab_uart_tx_if.slave    sys,
   output logic            Tx_Dout,
   output logic            Int_Req,
   input  logic            Int_Ack
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   localparam logic [1:0] A_DATA   = 2'd0;
   localparam logic [1:0] A_STATUS = 2'd1;
   localparam logic [1:0] A_CTRL   = 2'd2;
   localparam logic [1:0] A_BAUD   = 2'd3;

   logic [7:0]       r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] r_wptr;
   logic [PTR_W-1:0] r_rptr;
   logic [CNT_W-1:0] r_count;
   logic [1:0]       r_state;
   logic [7:0]       r_shift;
   logic [2:0]       r_bitidx;
   logic [DIV_W-1:0] r_bitcnt;
   logic [DIV_W-1:0] r_baud;
   logic             r_inten;
   logic             r_ovf;
   logic             r_done;
   logic             r_tx;
   logic             r_irq;
   logic [31:0]      r_rdata;

   logic             w_full;
   logic             w_empty;
   logic             w_push;
   logic             w_push_ok;
   logic             w_pop;
   logic             w_bit_end;
   logic             w_done_set;
   logic             w_done_clr;
   logic             w_line;
   logic [31:0]      w_status;
   logic [31:0]      w_rd_mux;

   assign w_full     = (r_count == CNT_W'(FIFO_DEPTH));
   assign w_empty    = (r_count == '0);
   assign w_push     = sys.Sys_WrEn && (sys.Sys_Address == A_DATA);
   assign w_bit_end  = (r_bitcnt == '0);
   assign w_pop      = !w_empty && ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end));
   // A full FIFO still accepts a byte when the transmitter pops in the same cycle.
   assign w_push_ok  = w_push && (!w_full || w_pop);
   assign w_done_set = (r_state == S_STOP) && w_bit_end && w_empty;
   assign w_done_clr = Int_Ack || w_push;

   assign w_status = {16'd0, 8'(r_count), 3'd0, r_done, r_ovf, w_empty, w_full, (r_state != S_IDLE)};

   always_comb begin
      w_rd_mux = '0;
      case (sys.Sys_Address)
         A_STATUS: w_rd_mux = w_status;
         A_CTRL:   w_rd_mux = {31'd0, r_inten};
         A_BAUD:   w_rd_mux = 32'(r_baud);
         default:  w_rd_mux = '0;
      endcase
   end

   // Line value for the current state; registered below, so the line trails the FSM by one cycle.
   always_comb begin
      w_line = 1'b1;
      case (r_state)
         S_START: w_line = 1'b0;
         S_DATA:  w_line = r_shift[0];
         default: w_line = 1'b1;
      endcase
   end

   always_ff @(posedge Sys_Clock) begin
      if (w_push_ok) begin
         r_mem[r_wptr] <= sys.Sys_WrData[7:0];
      end
      if (w_pop) begin
         r_shift <= r_mem[r_rptr];
      end else if ((r_state == S_DATA) && w_bit_end) begin
         r_shift <= r_shift >> 1;
      end
      // BAUD is re-sampled at every reload so a new rate applies from the next bit boundary.
      if (w_pop || ((r_state != S_IDLE) && w_bit_end)) begin
         r_bitcnt <= r_baud;
      end else if (r_state != S_IDLE) begin
         r_bitcnt <= r_bitcnt - 1'b1;
      end
      if ((r_state == S_START) && w_bit_end) begin
         r_bitidx <= 3'd0;
      end else if ((r_state == S_DATA) && w_bit_end) begin
         r_bitidx <= r_bitidx + 3'd1;
      end
   end

   always_ff @(posedge Sys_Clock) begin
      if (!Sys_Reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_state <= S_IDLE;
         r_inten <= 1'b0;
         r_baud  <= DIV_W'(DIV_RESET);
         r_ovf   <= 1'b0;
         r_done  <= 1'b0;
         r_tx    <= 1'b1;
         r_irq   <= 1'b0;
         r_rdata <= '0;
      end else begin
         if (w_push_ok) begin
            r_wptr <= r_wptr + 1'b1;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + 1'b1;
         end
         r_count <= r_count + CNT_W'(w_push_ok) - CNT_W'(w_pop);

         if (w_push && !w_push_ok) begin
            r_ovf <= 1'b1;
         end else if (sys.Sys_RdEn && (sys.Sys_Address == A_STATUS)) begin
            r_ovf <= 1'b0;
         end

         case (r_state)
            S_IDLE:  if (w_pop) r_state <= S_START;
            S_START: if (w_bit_end) r_state <= S_DATA;
            S_DATA:  if (w_bit_end && (r_bitidx == 3'd7)) r_state <= S_STOP;
            default: if (w_bit_end) r_state <= w_pop ? S_START : S_IDLE;
         endcase

         r_tx <= w_line;

         if (w_done_set) begin
            r_done <= 1'b1;
         end else if (w_done_clr) begin
            r_done <= 1'b0;
         end
         r_irq <= r_inten && r_done && !Int_Ack;

         if (sys.Sys_WrEn && (sys.Sys_Address == A_CTRL)) begin
            r_inten <= sys.Sys_WrData[0];
         end
         if (sys.Sys_WrEn && (sys.Sys_Address == A_BAUD)) begin
            r_baud <= sys.Sys_WrData[DIV_W-1:0];
         end
         if (sys.Sys_RdEn) begin
            r_rdata <= w_rd_mux;
         end
      end
   end

   assign Tx_Dout        = r_tx;
   assign Int_Req        = r_irq;
   assign sys.Sys_RdData = r_rdata;

endmodule

// File: tb/tb_kab_uart_tx.sv
// Directed bench for kab_uart_tx: register access, frame timing, FIFO overflow, interrupt and reset.
module tb_kab_uart_tx;

   logic        clk;
   logic        rst_n;
   logic        tx;
   logic        irq;
   logic        ack;
   logic [31:0] st;
   logic [9:0]  fr10;
   logic [19:0] fr20;
   int          n_cmp;
   int          n_fail;

   kab_uart_tx_if bus ();

   kab_uart_tx #(
      .FIFO_DEPTH (4),
      .DIV_W      (16),
      .DIV_RESET  (433)
   ) dut (
      .Sys_Clock (clk),
      .Sys_Reset (rst_n),
      .sys       (bus),
      .Tx_Dout   (tx),
      .Int_Req   (irq),
      .Int_Ack   (ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      bus.Sys_WrEn    = 1'b1;
      bus.Sys_Address = a;
      bus.Sys_WrData  = d;
      @(negedge clk);
      bus.Sys_WrEn    = 1'b0;
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] d);
      bus.Sys_RdEn    = 1'b1;
      bus.Sys_Address = a;
      @(negedge clk);
      bus.Sys_RdEn    = 1'b0;
      d = bus.Sys_RdData;
   endtask

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      rst_n  = 1'b0;
      ack    = 1'b0;
      bus.Sys_WrEn    = 1'b0;
      bus.Sys_RdEn    = 1'b0;
      bus.Sys_Address = 2'd0;
      bus.Sys_WrData  = 32'd0;
      repeat (3) @(negedge clk);

      // Reset values
      check("rst_tx", {31'd0, tx}, 32'd1);
      check("rst_irq", {31'd0, irq}, 32'd0);
      check("rst_rddata", bus.Sys_RdData, 32'd0);
      rst_n = 1'b1;
      rd(2'd1, st); check("rst_status", st, 32'h0000_0004);
      rd(2'd3, st); check("rst_baud", st, 32'd433);
      rd(2'd2, st); check("rst_ctrl", st, 32'd0);

      // One frame of 0xA5 at BAUD=3
      wr(2'd3, 32'd3);
      wr(2'd0, 32'h0000_00A5);
      @(negedge clk); check("a5_prestart", {31'd0, tx}, 32'd1);
      @(negedge clk); check("a5_start_lat", {31'd0, tx}, 32'd0);
      @(negedge clk);
      fr10 = 10'b11_0100_1010;
      for (int i = 0; i < 10; i++) begin
         check($sformatf("a5_bit%0d", i), {31'd0, tx}, {31'd0, fr10[i]});
         repeat (4) @(negedge clk);
      end
      check("a5_idle_tx", {31'd0, tx}, 32'd1);
      rd(2'd1, st); check("a5_status", st, 32'h0000_0014);

      // Back-to-back 0x01, 0x02: 20 contiguous bit periods, busy throughout
      wr(2'd0, 32'h0000_0001);
      wr(2'd0, 32'h0000_0002);
      @(negedge clk);
      fr20 = {1'b1, 8'h02, 1'b0, 1'b1, 8'h01, 1'b0};
      for (int k = 0; k < 20; k++) begin
         rd(2'd1, st);
         check($sformatf("b2b_bit%0d", k), {31'd0, tx}, {31'd0, fr20[k]});
         check($sformatf("b2b_busy%0d", k), {31'd0, st[0]}, 32'd1);
         repeat (3) @(negedge clk);
      end
      check("b2b_idle_tx", {31'd0, tx}, 32'd1);
      rd(2'd1, st); check("b2b_status", st, 32'h0000_0014);

      // BAUD=0: one cycle per bit, 0x96
      wr(2'd3, 32'd0);
      wr(2'd0, 32'h0000_0096);
      repeat (2) @(negedge clk);
      fr10 = {1'b1, 8'h96, 1'b0};
      for (int i = 0; i < 10; i++) begin
         check($sformatf("b0_bit%0d", i), {31'd0, tx}, {31'd0, fr10[i]});
         @(negedge clk);
      end
      rd(2'd1, st); check("b0_status", st, 32'h0000_0014);

      // Interrupt on drain, then acknowledge
      wr(2'd3, 32'd3);
      wr(2'd2, 32'd1);
      wr(2'd0, 32'h0000_005A);
      repeat (41) @(negedge clk);
      check("irq_before", {31'd0, irq}, 32'd0);
      @(negedge clk);
      check("irq_rise", {31'd0, irq}, 32'd1);
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      check("irq_ack_drop", {31'd0, irq}, 32'd0);
      rd(2'd1, st); check("irq_done_clr", st, 32'h0000_0004);

      // Acknowledge coinciding with the DONE set: DONE survives
      wr(2'd0, 32'h0000_00FF);
      repeat (40) @(negedge clk);
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      check("coinc_irq_low", {31'd0, irq}, 32'd0);
      @(negedge clk);
      check("coinc_irq_rise", {31'd0, irq}, 32'd1);
      rd(2'd1, st); check("coinc_done", st, 32'h0000_0014);
      wr(2'd2, 32'd0);
      @(negedge clk);
      check("inten_clr_irq", {31'd0, irq}, 32'd0);
      rd(2'd1, st); check("inten_clr_done", st, 32'h0000_0014);

      // Overflow with the transmitter stalled on the first byte
      wr(2'd3, 32'd1000);
      for (int i = 0; i < 6; i++) wr(2'd0, 32'h10 + i);
      rd(2'd1, st); check("ovf_status", st, 32'h0000_040B);
      rd(2'd1, st); check("ovf_cleared", st, 32'h0000_0403);

      // Reset during DATA bit 3 with two bytes queued
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      wr(2'd3, 32'd3);
      wr(2'd0, 32'h0000_0000);
      wr(2'd0, 32'h0000_0011);
      wr(2'd0, 32'h0000_0022);
      repeat (15) @(negedge clk);
      check("mid_bit2_line", {31'd0, tx}, 32'd0);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("mid_rst_tx", {31'd0, tx}, 32'd1);
      check("mid_rst_irq", {31'd0, irq}, 32'd0);
      check("mid_rst_rddata", bus.Sys_RdData, 32'd0);
      rd(2'd1, st); check("mid_rst_status", st, 32'h0000_0004);
      rd(2'd3, st); check("mid_rst_baud", st, 32'd433);
      repeat (10) @(negedge clk);
      check("mid_rst_quiet", {31'd0, tx}, 32'd1);

      // Register readback, masking and read latency
      wr(2'd3, 32'hFFFF_1234);
      wr(2'd2, 32'hFFFF_FFFF);
      rd(2'd2, st); check("rb_ctrl", st, 32'h0000_0001);
      bus.Sys_RdEn    = 1'b1;
      bus.Sys_Address = 2'd3;
      #1 check("rb_latency_old", bus.Sys_RdData, 32'h0000_0001);
      @(negedge clk);
      bus.Sys_RdEn = 1'b0;
      check("rb_baud", bus.Sys_RdData, 32'h0000_1234);
      repeat (3) @(negedge clk);
      check("rb_hold", bus.Sys_RdData, 32'h0000_1234);
      rd(2'd0, st); check("rb_data_zero", st, 32'd0);
      wr(2'd1, 32'hFFFF_FFFF);
      rd(2'd1, st); check("rb_status_ro", st, 32'h0000_0004);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
